// File: rtl/wash_pkg.sv
// wash_pkg: phase encoding and program codes shared by the coin/mode
// selector, the wash cycle controller and the display stage.
package wash_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        WASH  = 3'd2,
        RINSE = 3'd3,
        SPIN  = 3'd4,
        DONE  = 3'd5
    } phase_t;

    localparam logic [2:0] PROG_SHORT = 3'b001;
    localparam logic [2:0] PROG_LONG  = 3'b101;

    // True when a selector program code names a runnable program.
    function automatic logic isStartCode(input logic [2:0] code);
        return (code == PROG_SHORT) || (code == PROG_LONG);
    endfunction

endpackage

// File: rtl/wash_cycle_controller_if.sv
// Signal bundle between the selector/display side (master) and the
// wash cycle controller (slave).
interface wash_cycle_controller_if #(
    parameter int CNT_W = 8
);
    import wash_pkg::*;

    logic [3:0]       Mode;
    logic             Pause;
    logic             Abort;
    logic             isRunning;
    phase_t           Phase;
    logic [CNT_W-1:0] TimeLeft;
    logic             Done;

    modport master (
        output Mode, Pause, Abort,
        input  isRunning, Phase, TimeLeft, Done
    );

    modport slave (
        input  Mode, Pause, Abort,
        output isRunning, Phase, TimeLeft, Done
    );

endinterface

// File: rtl/wash_cycle_controller_tick_prescaler.sv
// tick_prescaler: divides the clock down to a one-cycle Tick every
// TICK_DIV enabled cycles. Clr restarts the count from zero.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic En,
    input  logic Clr,
    output logic Tick
);

    localparam int             CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_count;

    assign Tick = En && (r_count == LAST);

    // Enabled cycles advance the count; the wrapping cycle is the tick.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_count <= '0;
        end else if (Clr) begin
            r_count <= '0;
        end else if (En) begin
            if (r_count == LAST) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wash_cycle_controller.sv
// wash_cycle_controller: runs the selected wash program through FILL,
// WASH, RINSE and SPIN, counting seconds per phase, and reports the
// phase, remaining time and a completion pulse.
module wash_cycle_controller
    import wash_pkg::*;
#(
    parameter int TICK_DIV     = 50_000_000,
    parameter int FILL_T       = 2,
    parameter int WASH_SHORT_T = 5,
    parameter int WASH_LONG_T  = 10,
    parameter int RINSE_T      = 3,
    parameter int SPIN_T       = 4,
    parameter int CNT_W        = 8
) (
    input logic               Clk,
    input logic               Rst_n,
    wash_cycle_controller_if.slave bus
);

    localparam logic [CNT_W-1:0] L_FILL       = CNT_W'(FILL_T);
    localparam logic [CNT_W-1:0] L_WASH_SHORT = CNT_W'(WASH_SHORT_T);
    localparam logic [CNT_W-1:0] L_WASH_LONG  = CNT_W'(WASH_LONG_T);
    localparam logic [CNT_W-1:0] L_RINSE      = CNT_W'(RINSE_T);
    localparam logic [CNT_W-1:0] L_SPIN       = CNT_W'(SPIN_T);

    phase_t           r_phase;
    logic [CNT_W-1:0] r_timeLeft;
    logic             r_isRunning;
    logic             r_done;
    logic             r_progLong;
    logic             r_armed;

    logic [2:0]       w_code;
    logic             w_unusedModeBit;
    logic             w_start;
    logic             w_tick;
    logic             w_prescEn;
    logic             w_prescClr;
    logic [CNT_W-1:0] w_washDur;

    assign w_code          = bus.Mode[3:1];
    assign w_unusedModeBit = bus.Mode[0];

    // Abort in IDLE suppresses a start; an unarmed machine ignores the coin.
    assign w_start    = (r_phase == IDLE) && r_armed && !bus.Abort && isStartCode(w_code);
    assign w_prescEn  = r_isRunning && !bus.Pause && !bus.Abort;
    assign w_prescClr = (r_isRunning && bus.Abort) || w_start;
    assign w_washDur  = r_progLong ? L_WASH_LONG : L_WASH_SHORT;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .En    (w_prescEn),
        .Clr   (w_prescClr),
        .Tick  (w_tick)
    );

    // Program sequencer: phase, remaining time, run flag, done pulse, re-arm.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_phase     <= IDLE;
            r_timeLeft  <= '0;
            r_isRunning <= 1'b0;
            r_done      <= 1'b0;
            r_progLong  <= 1'b0;
            r_armed     <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_phase)
                IDLE: begin
                    if (w_start) begin
                        r_progLong  <= (w_code == PROG_LONG);
                        r_phase     <= FILL;
                        r_timeLeft  <= L_FILL;
                        r_isRunning <= 1'b1;
                        r_armed     <= 1'b0;
                    end else if (w_code == 3'b000) begin
                        r_armed <= 1'b1;
                    end
                end
                FILL, WASH, RINSE, SPIN: begin
                    if (bus.Abort) begin
                        r_phase     <= IDLE;
                        r_timeLeft  <= '0;
                        r_isRunning <= 1'b0;
                    end else if (w_tick) begin
                        if (r_timeLeft > 1) begin
                            r_timeLeft <= r_timeLeft - 1'b1;
                        end else begin
                            case (r_phase)
                                FILL: begin
                                    r_phase    <= WASH;
                                    r_timeLeft <= w_washDur;
                                end
                                WASH: begin
                                    r_phase    <= RINSE;
                                    r_timeLeft <= L_RINSE;
                                end
                                RINSE: begin
                                    r_phase    <= SPIN;
                                    r_timeLeft <= L_SPIN;
                                end
                                default: begin
                                    r_phase     <= DONE;
                                    r_timeLeft  <= '0;
                                    r_isRunning <= 1'b0;
                                    r_done      <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                default: begin
                    r_phase     <= IDLE;
                    r_timeLeft  <= '0;
                    r_isRunning <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Phase     = r_phase;
    assign bus.TimeLeft  = r_timeLeft;
    assign bus.isRunning = r_isRunning;
    assign bus.Done      = r_done;

endmodule

// File: tb/tb_wash_cycle_controller.sv
// Directed testbench for wash_cycle_controller with a four-cycle tick.
module tb_wash_cycle_controller;
    import wash_pkg::*;

    localparam int TICK_DIV = 4;
    localparam int CNT_W    = 8;
    localparam int NEVER    = 100000;

    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;
    int   checkCount = 0;
    int   errorCount = 0;

    wash_cycle_controller_if #(.CNT_W(CNT_W)) bus ();

    wash_cycle_controller #(
        .TICK_DIV     (TICK_DIV),
        .FILL_T       (2),
        .WASH_SHORT_T (5),
        .WASH_LONG_T  (10),
        .RINSE_T      (3),
        .SPIN_T       (4),
        .CNT_W        (CNT_W)
    ) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    // Free-running clock, period 10.
    always #5 Clk = ~Clk;

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Phase length in ticks for phase index 0..3.
    function automatic int segTicks(input int idx, input int washT);
        case (idx)
            0:       return 2;
            1:       return washT;
            2:       return 3;
            default: return 4;
        endcase
    endfunction

    // Expected phase m unpaused cycles after the start edge.
    function automatic int expPhase(input int m, input int washT);
        int base;
        base = 0;
        for (int p = 0; p < 4; p++) begin
            int len;
            len = segTicks(p, washT) * TICK_DIV;
            if (m < base + len) return p + 1;
            base += len;
        end
        return (m == base) ? 5 : 0;
    endfunction

    // Expected TimeLeft m unpaused cycles after the start edge.
    function automatic int expTimeLeft(input int m, input int washT);
        int base;
        base = 0;
        for (int p = 0; p < 4; p++) begin
            int len;
            len = segTicks(p, washT) * TICK_DIV;
            if (m < base + len) return segTicks(p, washT) - (m - base) / TICK_DIV;
            base += len;
        end
        return 0;
    endfunction

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] mode, input logic pause,
                                 input logic abort, input logic rstN);
        bus.Mode  = mode;
        bus.Pause = pause;
        bus.Abort = abort;
        Rst_n     = rstN;
        @(posedge Clk);
        #1;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " phase"},     int'(bus.Phase),     0);
        checkOutput({tag, " timeLeft"},  int'(bus.TimeLeft),  0);
        checkOutput({tag, " isRunning"}, int'(bus.isRunning), 0);
        checkOutput({tag, " done"},      int'(bus.Done),      0);
    endtask

    // Arm with Mode=0, then present the coin for one edge.
    task automatic startProgram(input logic [3:0] mode);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
        applyStimulus(mode, 1'b0, 1'b0, 1'b1);
    endtask

    // Walk the run cycle by cycle, comparing against the phase timeline.
    task automatic checkTimeline(input string tag, input int washT, input int stopAt,
                                 input int pauseAt, input int pauseLen,
                                 input logic [3:0] holdMode);
        int elapsed;
        int c;
        int ph;
        elapsed = 0;
        c = 0;
        while (1) begin
            ph = expPhase(elapsed, washT);
            checkOutput($sformatf("%s m=%0d phase", tag, elapsed), int'(bus.Phase), ph);
            checkOutput($sformatf("%s m=%0d timeLeft", tag, elapsed), int'(bus.TimeLeft),
                        expTimeLeft(elapsed, washT));
            checkOutput($sformatf("%s m=%0d isRunning", tag, elapsed), int'(bus.isRunning),
                        (ph >= 1 && ph <= 4) ? 1 : 0);
            checkOutput($sformatf("%s m=%0d done", tag, elapsed), int'(bus.Done),
                        (ph == 5) ? 1 : 0);
            if (elapsed >= stopAt) break;
            if (c >= pauseAt && c < pauseAt + pauseLen) begin
                applyStimulus(holdMode, 1'b1, 1'b0, 1'b1);
            end else begin
                applyStimulus(holdMode, 1'b0, 1'b0, 1'b1);
                elapsed++;
            end
            c++;
        end
    endtask

    logic [3:0] noStartModes [3];

    initial begin
        noStartModes = '{4'b0110, 4'b1110, 4'b1000};

        // Reset values
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        checkIdle("reset");

        // Short program: 8/20/12/16 cycles, Done at 56
        startProgram(4'b0010);
        checkTimeline("short", 5, 57, NEVER, 0, 4'b0000);

        // Long program: WASH 40 cycles, Done at 76
        startProgram(4'b1010);
        checkTimeline("long", 10, 77, NEVER, 0, 4'b0000);

        // Codes other than 001/101 never start
        foreach (noStartModes[i]) begin
            applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
            for (int k = 0; k < 3; k++) applyStimulus(noStartModes[i], 1'b0, 1'b0, 1'b1);
            checkOutput($sformatf("noStart %b phase", noStartModes[i]), int'(bus.Phase), 0);
            checkOutput($sformatf("noStart %b isRunning", noStartModes[i]), int'(bus.isRunning), 0);
        end

        // Mode[0] is ignored: 0011 still selects short
        startProgram(4'b0011);
        checkOutput("modeBit0 phase", int'(bus.Phase), 1);
        checkOutput("modeBit0 timeLeft", int'(bus.TimeLeft), 2);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b1);
        checkIdle("modeBit0 abort");

        // Ten paused cycles mid-WASH push Done from 56 to 66
        startProgram(4'b0010);
        checkTimeline("pause", 5, 57, 12, 10, 4'b0000);

        // Abort during RINSE
        startProgram(4'b0010);
        checkTimeline("abortRun", 5, 30, NEVER, 0, 4'b0000);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b1);
        checkIdle("abort");
        for (int k = 0; k < 40; k++) begin
            applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
            checkOutput($sformatf("abort after %0d done", k), int'(bus.Done), 0);
        end
        checkOutput("abort stays idle", int'(bus.Phase), 0);

        // Abort and Pause together: Abort wins
        startProgram(4'b0010);
        checkTimeline("abortPauseRun", 5, 30, NEVER, 0, 4'b0000);
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b1);
        checkIdle("abortPause");
        for (int k = 0; k < 40; k++) begin
            applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
            checkOutput($sformatf("abortPause after %0d done", k), int'(bus.Done), 0);
        end

        // Abort in IDLE blocks that cycle's start only
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'b0010, 1'b0, 1'b1, 1'b1);
        checkOutput("abortIdle phase", int'(bus.Phase), 0);
        applyStimulus(4'b0010, 1'b0, 1'b0, 1'b1);
        checkOutput("startAfterAbort phase", int'(bus.Phase), 1);
        checkOutput("startAfterAbort isRunning", int'(bus.isRunning), 1);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b1);
        checkIdle("startAfterAbort abort");

        // Coin held through completion does not restart
        startProgram(4'b0010);
        checkTimeline("hold", 5, 57, NEVER, 0, 4'b0010);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(4'b0010, 1'b0, 1'b0, 1'b1);
            checkOutput($sformatf("hold idle %0d phase", k), int'(bus.Phase), 0);
        end
        checkOutput("hold isRunning", int'(bus.isRunning), 0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'b0010, 1'b0, 1'b0, 1'b1);
        checkOutput("rearm phase", int'(bus.Phase), 1);
        checkOutput("rearm isRunning", int'(bus.isRunning), 1);
        checkOutput("rearm timeLeft", int'(bus.TimeLeft), 2);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b1);
        checkIdle("rearm abort");

        // Reset during SPIN
        startProgram(4'b0010);
        checkTimeline("preReset", 5, 44, NEVER, 0, 4'b0000);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        checkIdle("midReset");
        for (int k = 0; k < 20; k++) begin
            applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
            checkOutput($sformatf("postReset %0d done", k), int'(bus.Done), 0);
        end
        checkOutput("postReset phase", int'(bus.Phase), 0);

        // Reset leaves the machine armed
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0010, 1'b0, 1'b0, 1'b1);
        checkOutput("armedAfterReset phase", int'(bus.Phase), 1);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b1);
        checkIdle("armedAfterReset abort");

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
